// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU operations, forwarding selects
// and the divider state enumeration.
package exe_pkg;
  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_AND  = 4'd2;
  localparam logic [3:0] ALUOP_OR   = 4'd3;
  localparam logic [3:0] ALUOP_XOR  = 4'd4;
  localparam logic [3:0] ALUOP_NOR  = 4'd5;
  localparam logic [3:0] ALUOP_SLT  = 4'd6;
  localparam logic [3:0] ALUOP_SLTU = 4'd7;
  localparam logic [3:0] ALUOP_SLL  = 4'd8;
  localparam logic [3:0] ALUOP_SRL  = 4'd9;
  localparam logic [3:0] ALUOP_SRA  = 4'd10;
  localparam logic [3:0] ALUOP_LUI  = 4'd11;
  localparam logic [3:0] ALUOP_MULT = 4'd12;
  localparam logic [3:0] ALUOP_DIV  = 4'd13;
  localparam logic [3:0] ALUOP_MFHI = 4'd14;
  localparam logic [3:0] ALUOP_MFLO = 4'd15;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/exe_divider.sv
// Signed iterative restoring divider: one quotient bit per cycle on magnitudes,
// signs re-applied on the way out. Result is valid while done is high.
module exe_divider
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  div_state_t        state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem, quo, dvsr, dividend_q;
  logic              neg_q, neg_r, div_zero;
  logic [DATA_W:0]   trial;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start && !abort) state_nxt = DIV_BUSY;
      DIV_BUSY: begin
        if (abort)                       state_nxt = DIV_IDLE;
        else if (count == CNT_W'(1))     state_nxt = DIV_DONE;
      end
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV_BUSY);
    done = (state == DIV_DONE);
  end

  // quo shifts the dividend magnitude out at the top while quotient bits enter at the bottom
  assign trial = {rem, quo[DATA_W-1]} - {1'b0, dvsr};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
    end else if (state == DIV_IDLE && start && !abort) begin
      count      <= CNT_W'(DATA_W);
      rem        <= '0;
      quo        <= dividend[DATA_W-1] ? -dividend : dividend;
      dvsr       <= divisor[DATA_W-1] ? -divisor : divisor;
      dividend_q <= dividend;
      neg_q      <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
      neg_r      <= dividend[DATA_W-1];
      div_zero   <= (divisor == '0);
    end else if (state == DIV_BUSY) begin
      quo   <= {quo[DATA_W-2:0], ~trial[DATA_W]};
      if (!trial[DATA_W]) rem <= trial[DATA_W-1:0];
      else                rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
      count <= count - CNT_W'(1);
    end
  end

  assign quotient  = div_zero ? '1 : (neg_q ? -quo : quo);
  assign remainder = div_zero ? dividend_q : (neg_r ? -rem : rem);
endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, immediate select, ALU with MULT/DIV and HI/LO,
// plus the EX/MEM pipeline register. Stalls upstream while a divide runs.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exe_mem_flush,
  input  logic [3:0]        aluop_in,
  input  logic              s_b_in,
  input  logic [1:0]        s_forwardA_in,
  input  logic [1:0]        s_forwardB_in,
  input  logic [DATA_W-1:0] data_1_in,
  input  logic [DATA_W-1:0] data_2_in,
  input  logic [DATA_W-1:0] ext_imm_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic [31:0]       pc_4_in,
  input  logic [4:0]        num_write_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        s_data_write_in,
  output logic              exe_stall,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [31:0]       pc_4_out,
  output logic [4:0]        num_write_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [1:0]        s_data_write_out
);
  logic [DATA_W-1:0]   fwd_a, fwd_b, src_a, src_b, alu_res;
  logic [DATA_W-1:0]   hi, lo, div_q, div_r;
  logic [2*DATA_W-1:0] product;
  logic [4:0]          shamt;
  logic                div_busy, div_done, div_idle, div_start;

  always_comb begin
    case (s_forwardA_in)
      FWD_EXMEM: fwd_a = alu_result_out;
      FWD_WB:    fwd_a = wb_data_in;
      default:   fwd_a = data_1_in;
    endcase
    case (s_forwardB_in)
      FWD_EXMEM: fwd_b = alu_result_out;
      FWD_WB:    fwd_b = wb_data_in;
      default:   fwd_b = data_2_in;
    endcase
  end

  assign src_a   = fwd_a;
  assign src_b   = s_b_in ? ext_imm_in : fwd_b;
  assign shamt   = src_a[4:0];
  assign product = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};

  // In IDLE the stall is decoded straight from the opcode so the DIV is held in EX
  assign div_idle  = !div_busy && !div_done;
  assign div_start = div_idle && (aluop_in == ALUOP_DIV) && !exe_mem_flush;
  assign exe_stall = div_start || div_busy;

  exe_divider #(.DATA_W(DATA_W)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .abort     (exe_mem_flush),
    .dividend  (src_a),
    .divisor   (src_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    alu_res = '0;
    case (aluop_in)
      ALUOP_ADD:  alu_res = src_a + src_b;
      ALUOP_SUB:  alu_res = src_a - src_b;
      ALUOP_AND:  alu_res = src_a & src_b;
      ALUOP_OR:   alu_res = src_a | src_b;
      ALUOP_XOR:  alu_res = src_a ^ src_b;
      ALUOP_NOR:  alu_res = ~(src_a | src_b);
      ALUOP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALUOP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
      ALUOP_SLL:  alu_res = src_b << shamt;
      ALUOP_SRL:  alu_res = src_b >> shamt;
      ALUOP_SRA:  alu_res = $signed(src_b) >>> shamt;
      ALUOP_LUI:  alu_res = {src_b[15:0], {(DATA_W-16){1'b0}}};
      ALUOP_MULT: alu_res = product[DATA_W-1:0];
      ALUOP_DIV:  alu_res = div_q;
      ALUOP_MFHI: alu_res = hi;
      ALUOP_MFLO: alu_res = lo;
      default:    alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (!exe_mem_flush) begin
      if (div_done) begin
        lo <= div_q;
        hi <= div_r;
      end else if (div_idle && aluop_in == ALUOP_MULT) begin
        {hi, lo} <= product;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset || 1'b0) begin
      alu_result_out   <= '0;
      store_data_out   <= '0;
      pc_4_out         <= '0;
      num_write_out    <= '0;
      reg_write_out    <= 1'b0;
      mem_read_out     <= 1'b0;
      mem_write_out    <= 1'b0;
      s_data_write_out <= '0;
    end else if (exe_mem_flush || exe_stall) begin
      alu_result_out   <= '0;
      store_data_out   <= '0;
      pc_4_out         <= '0;
      num_write_out    <= '0;
      reg_write_out    <= 1'b0;
      mem_read_out     <= 1'b0;
      mem_write_out    <= 1'b0;
      s_data_write_out <= '0;
    end else begin
      alu_result_out   <= alu_res;
      store_data_out   <= fwd_b;
      pc_4_out         <= pc_4_in;
      num_write_out    <= num_write_in;
      reg_write_out    <= reg_write_in;
      mem_read_out     <= mem_read_in;
      mem_write_out    <= mem_write_in;
      s_data_write_out <= s_data_write_in;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: a table of single-cycle ALU vectors and
// hand-written divide / flush / reset sequences, all checked via a scoreboard.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exe_mem_flush;
  logic [3:0]  aluop_in;
  logic        s_b_in;
  logic [1:0]  s_forwardA_in, s_forwardB_in;
  logic [31:0] data_1_in, data_2_in, ext_imm_in, wb_data_in, pc_4_in;
  logic [4:0]  num_write_in;
  logic        reg_write_in, mem_read_in, mem_write_in;
  logic [1:0]  s_data_write_in;
  logic        exe_stall;
  logic [31:0] alu_result_out, store_data_out, pc_4_out;
  logic [4:0]  num_write_out;
  logic        reg_write_out, mem_read_out, mem_write_out;
  logic [1:0]  s_data_write_out;

  exe_stage #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset), .exe_mem_flush(exe_mem_flush),
    .aluop_in(aluop_in), .s_b_in(s_b_in),
    .s_forwardA_in(s_forwardA_in), .s_forwardB_in(s_forwardB_in),
    .data_1_in(data_1_in), .data_2_in(data_2_in), .ext_imm_in(ext_imm_in),
    .wb_data_in(wb_data_in), .pc_4_in(pc_4_in), .num_write_in(num_write_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .s_data_write_in(s_data_write_in),
    .exe_stall(exe_stall), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .pc_4_out(pc_4_out),
    .num_write_out(num_write_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .s_data_write_out(s_data_write_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res, store, pc;
    logic [4:0]  num;
    logic        rw, mr, mw;
    logic [1:0]  sdw;
    bit          chk_res;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic        sb;
    logic [1:0]  fa, fb;
    logic [31:0] d1, d2, imm, wb, exp_res, exp_store;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[17];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic sb, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [31:0] wb, input logic [7:0] idx);
    aluop_in = op; s_b_in = sb; s_forwardA_in = fa; s_forwardB_in = fb;
    data_1_in = d1; data_2_in = d2; ext_imm_in = imm; wb_data_in = wb;
    pc_4_in = 32'h1000 + {22'd0, idx, 2'b00};
    num_write_in = idx[4:0];
    reg_write_in = 1'b1; mem_read_in = idx[0]; mem_write_in = idx[1];
    s_data_write_in = idx[2:1];
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] store, input logic [7:0] idx, input bit cr);
    exp_t e;
    e.res = res; e.store = store; e.pc = 32'h1000 + {22'd0, idx, 2'b00};
    e.num = idx[4:0]; e.rw = 1'b1; e.mr = idx[0]; e.mw = idx[1]; e.sdw = idx[2:1];
    e.chk_res = cr;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e.res = '0; e.store = '0; e.pc = '0; e.num = '0;
    e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.sdw = '0; e.chk_res = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock); #1;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue want an entry");
    end else begin
      e = sb_q.pop_front();
      if (e.chk_res) chk("alu_result", alu_result_out, e.res);
      chk("store_data", store_data_out, e.store);
      chk("pc_4", pc_4_out, e.pc);
      chk("num_write", {27'd0, num_write_out}, {27'd0, e.num});
      chk("ctrl", {28'd0, reg_write_out, mem_read_out, mem_write_out, 1'b0},
                  {28'd0, e.rw, e.mr, e.mw, 1'b0});
      chk("s_data_write", {30'd0, s_data_write_out}, {30'd0, e.sdw});
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_stall"}, {31'd0, exe_stall}, 32'd0);
    chk({name, "_result"}, alu_result_out, 32'd0);
    chk({name, "_store"}, store_data_out, 32'd0);
    chk({name, "_pc"}, pc_4_out, 32'd0);
    chk({name, "_ctrl"}, {20'd0, num_write_out, reg_write_out, mem_read_out, mem_write_out, s_data_write_out},
                         32'd0);
  endtask

  // DIV followed by MFLO/MFHI; the stall length is counted with a bound
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input logic [7:0] idx);
    int n;
    drive(ALUOP_DIV, 1'b0, FWD_REG, FWD_REG, a, b, 32'd0, 32'd0, idx);
    #1;
    chk("div_stall_start", {31'd0, exe_stall}, 32'd1);
    n = 0;
    while (exe_stall && n < 100) begin
      n++;
      push_bubble();
      tick();
    end
    chk("div_stall_cycles", n, 33);
    push(32'd0, b, idx, 1'b0);
    tick();
    drive(ALUOP_MFLO, 1'b0, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0, idx + 8'd1);
    push(q, 32'd0, idx + 8'd1, 1'b1);
    tick();
    drive(ALUOP_MFHI, 1'b0, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0, idx + 8'd2);
    push(r, 32'd0, idx + 8'd2, 1'b1);
    tick();
  endtask

  initial begin
    //          op          sb    fa         fb         d1            d2            imm           wb            res           store
    vecs[0]  = '{ALUOP_ADD,  1'b0, FWD_REG,   FWD_REG,   32'd5,        32'd7,        32'd0,        32'd0,        32'd12,       32'd7};
    vecs[1]  = '{ALUOP_SUB,  1'b1, FWD_EXMEM, FWD_REG,   32'h99,       32'd0,        32'd3,        32'd0,        32'd9,        32'd0};
    vecs[2]  = '{ALUOP_SRA,  1'b0, FWD_REG,   FWD_WB,    32'd4,        32'h55,       32'd0,        32'h80000000, 32'hF8000000, 32'h80000000};
    vecs[3]  = '{ALUOP_AND,  1'b0, FWD_REG,   FWD_REG,   32'hF0F0,     32'hFF00,     32'd0,        32'd0,        32'hF000,     32'hFF00};
    vecs[4]  = '{ALUOP_OR,   1'b0, FWD_REG,   FWD_REG,   32'hF0F0,     32'hFF00,     32'd0,        32'd0,        32'hFFF0,     32'hFF00};
    vecs[5]  = '{ALUOP_XOR,  1'b0, FWD_REG,   FWD_REG,   32'hF0F0,     32'hFF00,     32'd0,        32'd0,        32'h0FF0,     32'hFF00};
    vecs[6]  = '{ALUOP_NOR,  1'b0, FWD_REG,   FWD_REG,   32'd0,        32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 32'd0};
    vecs[7]  = '{ALUOP_SLT,  1'b0, FWD_REG,   FWD_REG,   32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd1,        32'd1};
    vecs[8]  = '{ALUOP_SLTU, 1'b0, FWD_REG,   FWD_REG,   32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        32'd1};
    vecs[9]  = '{ALUOP_SLL,  1'b0, FWD_REG,   FWD_REG,   32'h24,       32'd1,        32'd0,        32'd0,        32'd16,       32'd1};
    vecs[10] = '{ALUOP_SRL,  1'b0, FWD_REG,   FWD_REG,   32'd4,        32'h80000000, 32'd0,        32'd0,        32'h08000000, 32'h80000000};
    vecs[11] = '{ALUOP_LUI,  1'b1, FWD_REG,   FWD_REG,   32'd0,        32'hABCD,     32'h1234,     32'd0,        32'h12340000, 32'hABCD};
    vecs[12] = '{ALUOP_ADD,  1'b0, FWD_REG,   FWD_REG,   32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        32'd1};
    vecs[13] = '{ALUOP_MULT, 1'b0, FWD_REG,   FWD_REG,   32'h10000,    32'h10000,    32'd0,        32'd0,        32'd0,        32'h10000};
    vecs[14] = '{ALUOP_MFHI, 1'b0, FWD_REG,   FWD_REG,   32'd0,        32'd0,        32'd0,        32'd0,        32'd1,        32'd0};
    vecs[15] = '{ALUOP_ADD,  1'b0, 2'b11,     FWD_EXMEM, 32'd3,        32'd9,        32'd0,        32'd0,        32'd4,        32'd1};
    vecs[16] = '{ALUOP_MFLO, 1'b0, FWD_REG,   FWD_REG,   32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        32'd0};

    exe_mem_flush = 1'b0;
    drive(ALUOP_ADD, 1'b0, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0);
    #1 reset = 1'b1;
    #10;
    check_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].sb, vecs[i].fa, vecs[i].fb, vecs[i].d1, vecs[i].d2,
            vecs[i].imm, vecs[i].wb, 8'(i + 1));
      push(vecs[i].exp_res, vecs[i].exp_store, 8'(i + 1), 1'b1);
      tick();
    end

    run_div(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 8'd20);
    run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 8'd24);
    run_div(32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 8'd28);

    // flush part-way through a divide: HI/LO keep the 100/0 results
    drive(ALUOP_DIV, 1'b0, FWD_REG, FWD_REG, 32'd50, 32'd5, 32'd0, 32'd0, 8'd40);
    for (int i = 0; i < 10; i++) begin
      push_bubble();
      tick();
    end
    chk("flush_stall_before", {31'd0, exe_stall}, 32'd1);
    exe_mem_flush = 1'b1;
    push_bubble();
    tick();
    exe_mem_flush = 1'b0;
    drive(ALUOP_MFLO, 1'b0, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0, 8'd41);
    #1;
    chk("flush_stall_after", {31'd0, exe_stall}, 32'd0);
    push(32'hFFFFFFFF, 32'd0, 8'd41, 1'b1);
    tick();
    drive(ALUOP_MFHI, 1'b0, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0, 8'd42);
    push(32'd100, 32'd0, 8'd42, 1'b1);
    tick();

    // asynchronous reset in the middle of a divide
    drive(ALUOP_DIV, 1'b0, FWD_REG, FWD_REG, 32'd9, 32'd3, 32'd0, 32'd0, 8'd50);
    for (int i = 0; i < 5; i++) begin
      push_bubble();
      tick();
    end
    #2;
    reset = 1'b1;
    drive(ALUOP_ADD, 1'b0, FWD_REG, FWD_REG, 32'd1, 32'd1, 32'd0, 32'd0, 8'd51);
    #1;
    check_zero("mid_div_reset");
    sb_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    push(32'd2, 32'd1, 8'd51, 1'b1);
    tick();
    drive(ALUOP_MFHI, 1'b0, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0, 8'd52);
    push(32'd0, 32'd0, 8'd52, 1'b1);
    tick();
    drive(ALUOP_MFLO, 1'b0, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0, 8'd53);
    push(32'd0, 32'd0, 8'd53, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
